// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks the mux select code through every channel, holds each
// code for SETTLE cycles, samples F on the last one into Q, then offers Q with
// a Valid/Ready handshake. Synchronous active-high reset; all outputs registered.
module mux_scan_ctrl #(
    parameter int SEL_W  = 4,
    parameter int SETTLE = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic                   i_f,
    input  logic                   i_ready,
    output logic [SEL_W-1:0]       o_s,
    output logic                   o_en,
    output logic                   o_busy,
    output logic [0:(1<<SEL_W)-1]  o_q,
    output logic                   o_valid
);
    localparam int NCH   = 1 << SEL_W;
    // SETTLE-1 is the largest value the hold counter ever takes
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [SEL_W-1:0] LAST_S   = SEL_W'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_s,     w_s_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [0:NCH-1]   r_q,     w_q_nxt;
    logic             r_en,    w_en_nxt;
    logic             r_valid, w_valid_nxt;

    // State and datapath registers; reset overrides every input
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_en    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_en    <= w_en_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Next-state and next-output decode; everything holds unless a branch moves it
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_en_nxt    = r_en;
        w_valid_nxt = r_valid;
        case (r_state)
            IDLE: begin
                // Level-sensitive: a held Start re-arms on every IDLE visit
                if (i_start) begin
                    w_state_nxt = SCAN;
                    w_s_nxt     = '0;
                    w_cnt_nxt   = CNT_LOAD;
                    w_en_nxt    = 1'b1;
                end
            end
            SCAN: begin
                // Abort wins over a capture due on the same edge; Q keeps partial data
                if (i_abort) begin
                    w_state_nxt = IDLE;
                    w_s_nxt     = '0;
                    w_cnt_nxt   = '0;
                    w_en_nxt    = 1'b0;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_q_nxt[r_s] = i_f;
                    if (r_s == LAST_S) begin
                        // Last channel ends the scan rather than wrapping S
                        w_state_nxt = DONE;
                        w_s_nxt     = '0;
                        w_en_nxt    = 1'b0;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_s_nxt   = r_s + 1'b1;
                        w_cnt_nxt = CNT_LOAD;
                    end
                end
            end
            DONE: begin
                // Q frozen until handshake; Start is not looked at here
                if (i_ready) begin
                    w_state_nxt = IDLE;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_s_nxt     = '0;
                w_cnt_nxt   = '0;
                w_en_nxt    = 1'b0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign o_s     = r_s;
    assign o_en    = r_en;
    assign o_busy  = (r_state != IDLE);
    assign o_q     = r_q;
    assign o_valid = r_valid;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: default 16-channel/SETTLE=2 instance plus a
// 4-channel/SETTLE=1 instance. Expected Q words go into a scoreboard queue when
// a scan is launched and are popped when the DUT presents its result.
module tb_mux_scan_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        rst0, st0, ab0, rdy0, f0;
    logic [3:0]  s0;
    logic        en0, busy0, v0;
    logic [0:15] q0;
    logic [0:15] w0;
    assign f0 = w0[s0];

    // small instance: SEL_W=2, SETTLE=1
    logic        rst1, st1, ab1, rdy1, f1;
    logic [1:0]  s1;
    logic        en1, busy1, v1;
    logic [0:3]  q1;
    logic [0:3]  w1;
    assign f1 = w1[s1];

    mux_scan_ctrl u_dut0 (
        .i_clk(clk), .i_rst(rst0), .i_start(st0), .i_abort(ab0), .i_f(f0),
        .i_ready(rdy0), .o_s(s0), .o_en(en0), .o_busy(busy0), .o_q(q0), .o_valid(v0)
    );

    mux_scan_ctrl #(.SEL_W(2), .SETTLE(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst1), .i_start(st1), .i_abort(ab1), .i_f(f1),
        .i_ready(rdy1), .o_s(s1), .o_en(en1), .o_busy(busy1), .o_q(q1), .o_valid(v1)
    );

    int errs   = 0;
    int checks = 0;
    logic [15:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // outputs sampled 1 time unit after the active edge; inputs driven there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_s"},     32'(s0),    0);
        chk({tag, "_en"},    32'(en0),   0);
        chk({tag, "_busy"},  32'(busy0), 0);
        chk({tag, "_valid"}, 32'(v0),    0);
        chk({tag, "_q"},     32'(q0),    0);
    endtask

    // Launch a full scan of word w on the default instance and check the
    // select walk, the Valid latency and the scoreboarded Q word.
    task automatic scan0(input logic [0:15] w, input logic hold_start);
        int k;
        logic [15:0] e;
        w0   = w;
        st0  = 1'b1;
        rdy0 = 1'b0;
        sb_q.push_back(w);
        tick();                       // start edge
        st0 = hold_start;
        chk("start_busy", 32'(busy0), 1);
        chk("start_en",   32'(en0),   1);
        chk("start_s",    32'(s0),    0);
        for (k = 1; k <= 64; k++) begin
            tick();
            if (v0) break;
            chk("s_step", 32'(s0), 32'(k / 2));
        end
        chk("latency", 32'(k), 32);
        e = sb_q.pop_front();
        chk("q_word", 32'(q0), 32'(e));
        chk("done_en", 32'(en0), 0);
        chk("done_s",  32'(s0),  0);
        chk("done_busy", 32'(busy0), 1);
    endtask

    initial begin
        logic [15:0] e;
        logic [0:15] exp_part;
        logic [0:15] wa;
        int k;
        rst0 = 1'b1; st0 = 1'b0; ab0 = 1'b0; rdy0 = 1'b0; w0 = '0;
        rst1 = 1'b1; st1 = 1'b0; ab1 = 1'b0; rdy1 = 1'b0; w1 = '0;
        tick(); tick();
        rst0 = 1'b0; rst1 = 1'b0;
        chk_reset0("rst");
        tick();
        chk("idle_busy", 32'(busy0), 0);

        // basic scan, then Ready withheld for 10 cycles
        scan0(16'hA5C3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", 32'(v0), 1);
            chk("hold_q", 32'(q0), 32'h0000_A5C3);
        end
        rdy0 = 1'b1;
        tick();
        rdy0 = 1'b0;
        chk("hs_valid", 32'(v0), 0);
        chk("hs_busy",  32'(busy0), 0);
        chk("hs_q_kept", 32'(q0), 32'h0000_A5C3);

        // abort on S==7 at the same edge its capture would happen
        wa = 16'h5A3C;
        exp_part = q0;
        for (int i = 0; i < 7; i++) exp_part[i] = wa[i];
        sb_q.push_back(exp_part);
        w0 = wa;
        st0 = 1'b1;
        tick();
        st0 = 1'b0;
        for (int i = 1; i <= 15; i++) tick();
        chk("abort_pre_s", 32'(s0), 7);
        ab0 = 1'b1;
        tick();
        ab0 = 1'b0;
        e = sb_q.pop_front();
        chk("abort_busy", 32'(busy0), 0);
        chk("abort_en",   32'(en0),   0);
        chk("abort_s",    32'(s0),    0);
        chk("abort_q",    32'(q0),    32'(e));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("abort_novalid", 32'(v0), 0);
        end

        // Start held through the scan and across the handshake edge
        scan0(16'h1234, 1'b1);
        rdy0 = 1'b1;
        tick();
        rdy0 = 1'b0;
        chk("hs_start_busy",  32'(busy0), 0);
        chk("hs_start_valid", 32'(v0),    0);
        chk("hs_start_en",    32'(en0),   0);
        tick();
        chk("rearm_busy", 32'(busy0), 1);
        chk("rearm_en",   32'(en0),   1);
        chk("rearm_s",    32'(s0),    0);
        st0 = 1'b0;
        for (int i = 1; i <= 18; i++) tick();
        chk("mid_s", 32'(s0), 9);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        chk_reset0("rst_mid");

        // reset while DONE
        scan0(16'h8001, 1'b0);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        chk_reset0("rst_done");

        // small instance: one cycle per code
        w1 = 4'b1001;
        sb_q.push_back(16'(w1));
        st1 = 1'b1;
        tick();
        st1 = 1'b0;
        chk("s1_start", 32'(s1), 0);
        chk("s1_en", 32'(en1), 1);
        for (k = 1; k <= 16; k++) begin
            tick();
            if (v1) break;
            chk("s1_step", 32'(s1), 32'(k));
        end
        chk("s1_latency", 32'(k), 4);
        e = sb_q.pop_front();
        chk("s1_q", 32'(q1), 32'(e));
        chk("s1_done_en", 32'(en1), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errs, checks);
        $fatal(1);
    end
endmodule
